// File: rtl/instr_fetch.sv
// Fetch stage of the 16-bit RISC pipeline.
// Owns the PC, presents it to a zero-latency instruction ROM and registers the
// returned word into the IF/ID pipeline register. Supports hazard stalls,
// branch/jump redirect with flush of the wrong-path word, and a HALT state
// entered when the PC runs past the end of the ROM.
module instr_fetch #(
    parameter int                PC_W      = 16,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter int                ROM_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_pc,
    input  logic [15:0]     imem_instr,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc1,
    output logic            ifid_valid,
    output logic            halted,
    output logic [15:0]     fetch_cnt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // One bit wider than the PC so a ROM that fills the whole address space
    // (ROM_DEPTH = 2**PC_W) is representable and never flags out-of-range.
    localparam logic [PC_W:0] ROM_LIMIT = (PC_W+1)'(ROM_DEPTH);

    state_t          state_q,      state_d;
    logic [PC_W-1:0] pc_q,         pc_d;
    logic [15:0]     ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0] ifid_pc1_q,   ifid_pc1_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [15:0]     fetch_cnt_q,  fetch_cnt_d;

    logic [PC_W-1:0] pc_plus1;
    logic            out_of_range;

    assign pc_plus1     = pc_q + PC_W'(1);
    assign out_of_range = ({1'b0, pc_q} >= ROM_LIMIT);

    // State and datapath registers; reset takes effect immediately.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc1_q   <= '0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc1_q   <= ifid_pc1_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Next state: redirect always resumes RUN; running off the ROM halts.
    always_comb begin
        // NOTE: default-first assignment keeps every comb output driven on
        // all paths, so no latch is inferred.
        state_d = state_q;
        if (redirect) begin
            state_d = S_RUN;
        end else if ((state_q == S_RUN) && !stall && out_of_range) begin
            state_d = S_HALT;
        end
    end

    // State-derived outputs.
    always_comb begin
        halted = (state_q == S_HALT);
    end

    // PC, IF/ID and counter update; priority redirect > stall > range > fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc1_d   = ifid_pc1_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (redirect) begin
            // Flush the wrong-path word that is being fetched this cycle.
            pc_d         = redirect_pc;
            ifid_instr_d = '0;
            ifid_pc1_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (stall && (state_q == S_RUN)) begin
            // Hold everything; defaults already do that.
        end else if ((state_q == S_HALT) || out_of_range) begin
            // Halted (stall irrelevant) or about to halt: emit bubbles.
            ifid_instr_d = '0;
            ifid_pc1_d   = '0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = imem_instr;
            ifid_pc1_d   = pc_plus1;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus1;
            if (fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
        end
    end

    assign imem_pc    = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc1   = ifid_pc1_q;
    assign ifid_valid = ifid_valid_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven vectors through a
// scoreboard queue, plus hand-written reset, full-address-space wrap and
// post-reset sequential-run sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;

    // Main DUT: 16-word ROM.
    logic [15:0] imem_pc, imem_instr, redirect_pc, ifid_instr, ifid_pc1, fetch_cnt;
    logic        stall, redirect, ifid_valid, halted;

    // Second DUT: ROM spans the whole address space, data = ~address.
    logic [15:0] imem_pc2, imem_instr2, redirect_pc2, ifid_instr2, ifid_pc1_2, fetch_cnt2;
    logic        stall2, redirect2, ifid_valid2, halted2;

    logic [15:0] rom [16] = '{16'h444f, 16'h465f, 16'h14c0, 16'h5040,
                              16'h4840, 16'h8b86, 16'h0000, 16'h7a01,
                              16'hc3d2, 16'h2e5b, 16'hb00c, 16'h9202,
                              16'h6a6a, 16'h0f0f, 16'hdead, 16'hbeef};

    assign imem_instr  = (imem_pc < 16'd16) ? rom[imem_pc[3:0]] : 16'h0000;
    assign imem_instr2 = ~imem_pc2;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(16), .RESET_PC(16'h0000), .ROM_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_cnt(fetch_cnt)
    );

    instr_fetch #(.PC_W(16), .RESET_PC(16'h0000), .ROM_DEPTH(65536)) dut2 (
        .clk(clk), .rst(rst), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
        .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .ifid_instr(ifid_instr2), .ifid_pc1(ifid_pc1_2), .ifid_valid(ifid_valid2),
        .halted(halted2), .fetch_cnt(fetch_cnt2)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] redirect_pc;
        logic [15:0] e_instr;
        logic [15:0] e_pc1;
        logic        e_valid;
        logic        e_halted;
        logic [15:0] e_cnt;
        logic [15:0] e_pc;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rpc,
                                input logic [15:0] ins, input logic [15:0] pc1,
                                input logic v, input logic h,
                                input logic [15:0] cnt, input logic [15:0] pc);
        vec_t t;
        t.stall = s; t.redirect = r; t.redirect_pc = rpc;
        t.e_instr = ins; t.e_pc1 = pc1; t.e_valid = v; t.e_halted = h;
        t.e_cnt = cnt; t.e_pc = pc;
        return t;
    endfunction

    // Drive one vector for one clock edge; expectation goes through the queue.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.redirect_pc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".instr"},  ifid_instr,        e.e_instr);
            check({tag, ".pc1"},    ifid_pc1,          e.e_pc1);
            check({tag, ".valid"},  {15'd0, ifid_valid}, {15'd0, e.e_valid});
            check({tag, ".halted"}, {15'd0, halted},   {15'd0, e.e_halted});
            check({tag, ".cnt"},    fetch_cnt,         e.e_cnt);
            check({tag, ".pc"},     imem_pc,           e.e_pc);
        end
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        //             stall rd  rpc       instr     pc1       v  h  cnt      pc
        vecs[0]  = mk(0, 0, 16'h0000, 16'h444f, 16'h0001, 1, 0, 16'd1,  16'h0001);
        vecs[1]  = mk(0, 0, 16'h0000, 16'h465f, 16'h0002, 1, 0, 16'd2,  16'h0002);
        vecs[2]  = mk(0, 0, 16'h0000, 16'h14c0, 16'h0003, 1, 0, 16'd3,  16'h0003);
        vecs[3]  = mk(1, 0, 16'h0000, 16'h14c0, 16'h0003, 1, 0, 16'd3,  16'h0003);
        vecs[4]  = mk(1, 0, 16'h0000, 16'h14c0, 16'h0003, 1, 0, 16'd3,  16'h0003);
        vecs[5]  = mk(0, 0, 16'h0000, 16'h5040, 16'h0004, 1, 0, 16'd4,  16'h0004);
        vecs[6]  = mk(0, 0, 16'h0000, 16'h4840, 16'h0005, 1, 0, 16'd5,  16'h0005);
        vecs[7]  = mk(0, 1, 16'h0001, 16'h0000, 16'h0000, 0, 0, 16'd5,  16'h0001);
        vecs[8]  = mk(0, 0, 16'h0000, 16'h465f, 16'h0002, 1, 0, 16'd6,  16'h0002);
        vecs[9]  = mk(1, 1, 16'h000b, 16'h0000, 16'h0000, 0, 0, 16'd6,  16'h000b);
        vecs[10] = mk(0, 0, 16'h0000, 16'h9202, 16'h000c, 1, 0, 16'd7,  16'h000c);
        vecs[11] = mk(1, 0, 16'h0000, 16'h9202, 16'h000c, 1, 0, 16'd7,  16'h000c);
        vecs[12] = mk(0, 0, 16'h0000, 16'h6a6a, 16'h000d, 1, 0, 16'd8,  16'h000d);
        vecs[13] = mk(0, 0, 16'h0000, 16'h0f0f, 16'h000e, 1, 0, 16'd9,  16'h000e);
        vecs[14] = mk(0, 0, 16'h0000, 16'hdead, 16'h000f, 1, 0, 16'd10, 16'h000f);
        vecs[15] = mk(0, 0, 16'h0000, 16'hbeef, 16'h0010, 1, 0, 16'd11, 16'h0010);
        vecs[16] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd11, 16'h0010);
        vecs[17] = mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd11, 16'h0010);
        vecs[18] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd11, 16'h0010);
        vecs[19] = mk(0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd11, 16'h0000);
        vecs[20] = mk(0, 0, 16'h0000, 16'h444f, 16'h0001, 1, 0, 16'd12, 16'h0001);
        vecs[21] = mk(0, 1, 16'h0020, 16'h0000, 16'h0000, 0, 0, 16'd12, 16'h0020);
        vecs[22] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd12, 16'h0020);
        vecs[23] = mk(1, 1, 16'hffff, 16'h0000, 16'h0000, 0, 0, 16'd12, 16'hffff);
        vecs[24] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd12, 16'hffff);
        vecs[25] = mk(0, 1, 16'h0006, 16'h0000, 16'h0000, 0, 0, 16'd12, 16'h0006);
        vecs[26] = mk(0, 0, 16'h0000, 16'h0000, 16'h0007, 1, 0, 16'd13, 16'h0007);
        vecs[27] = mk(0, 0, 16'h0000, 16'h7a01, 16'h0008, 1, 0, 16'd14, 16'h0008);
        vecs[28] = mk(0, 1, 16'h0030, 16'h0000, 16'h0000, 0, 0, 16'd14, 16'h0030);
        vecs[29] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd14, 16'h0030);

        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        stall2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 16'h0000;

        // Reset state.
        #2;
        check("reset.pc",     imem_pc,              16'h0000);
        check("reset.valid",  {15'd0, ifid_valid},  16'd0);
        check("reset.halted", {15'd0, halted},      16'd0);
        check("reset.cnt",    fetch_cnt,            16'd0);
        check("reset.instr",  ifid_instr,           16'h0000);
        check("reset.pc1",    ifid_pc1,             16'h0000);
        @(posedge clk);
        #2 rst = 1'b0;

        // Main table.
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Full-address-space ROM: 16'hFFFF wraps to 0, and word 0000 is valid.
        @(negedge clk);
        redirect2 = 1'b1; redirect_pc2 = 16'hffff;   // stall2 still 1: redirect wins
        @(posedge clk); #1;
        check("wrap.redir_pc",    imem_pc2,             16'hffff);
        check("wrap.redir_valid", {15'd0, ifid_valid2}, 16'd0);
        @(negedge clk);
        redirect2 = 1'b0; stall2 = 1'b0;
        @(posedge clk); #1;
        check("wrap.pc",    imem_pc2,             16'h0000);
        check("wrap.instr", ifid_instr2,          16'h0000);
        check("wrap.valid", {15'd0, ifid_valid2}, 16'd1);
        check("wrap.pc1",   ifid_pc1_2,           16'h0000);
        check("wrap.cnt",   fetch_cnt2,           16'd1);
        stall2 = 1'b1;

        // Asynchronous reset mid-operation while main DUT is halted.
        @(negedge clk);
        check("pre_rst.halted", {15'd0, halted}, 16'd1);
        rst = 1'b1;
        #1;
        check("midrst.pc",     imem_pc,             16'h0000);
        check("midrst.valid",  {15'd0, ifid_valid}, 16'd0);
        check("midrst.halted", {15'd0, halted},     16'd0);
        check("midrst.cnt",    fetch_cnt,           16'd0);
        check("midrst.cnt2",   fetch_cnt2,          16'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Sequential run out of reset: ROM words 0..5, PC+1 = 1..6, count 6.
        for (int i = 0; i < 6; i++) begin
            apply(mk(0, 0, 16'h0000, rom[i], 16'(i + 1), 1, 0, 16'(i + 1), 16'(i + 1)),
                  $sformatf("seq%0d", i));
        end
        check("seq.final_cnt", fetch_cnt, 16'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
